// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares one data-memory port among per-thread load/store consumers
//
// Grants one consumer at a time. The granted request is forwarded to memory.
// The memory response is relayed back to the granted consumer.
// At most one transaction is in flight.
//
// Ports:
//   clk, reset                : clock (rising edge), asynchronous active-high reset
//   consumer_read_valid/address  : per-consumer read requests (packed, ADDR_BITS per consumer)
//   consumer_read_ready/data     : per-consumer read response strobe and held read-data slot
//   consumer_write_valid/address/data : per-consumer write requests
//   consumer_write_ready         : per-consumer write acknowledge
//   mem_read_valid/address, mem_read_ready/data : shared memory read port
//   mem_write_valid/address/data, mem_write_ready : shared memory write port
//
// Build option:
//   MEM_ARB_FIXED_PRIORITY_EN - the scan always starts at consumer 0 (lowest index wins).
//   When it is undefined, the scan starts at a round-robin pointer.

module data_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);

    localparam int IDX_BITS = $clog2(NUM_CONSUMERS);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t                           state, state_n;
    logic [IDX_BITS-1:0]              grant, grant_n;
    logic                             is_read, is_read_n;
    logic [IDX_BITS-1:0]              scan_start;
    logic [IDX_BITS:0]                cand;
    logic                             found;
    logic [IDX_BITS-1:0]              pick;
    logic                             relay_done;

    logic [NUM_CONSUMERS-1:0]           consumer_read_ready_n;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_n;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready_n;
    logic                               mem_read_valid_n;
    logic [ADDR_BITS-1:0]               mem_read_address_n;
    logic                               mem_write_valid_n;
    logic [ADDR_BITS-1:0]               mem_write_address_n;
    logic [DATA_BITS-1:0]               mem_write_data_n;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    assign scan_start = '0;
`else
    logic [IDX_BITS-1:0] rr_ptr, rr_ptr_n;
    logic [IDX_BITS:0]   grant_inc;
    logic [IDX_BITS-1:0] grant_next;

    assign scan_start = rr_ptr;
    assign grant_inc  = {1'b0, grant} + (IDX_BITS+1)'(1);
    // The pointer moves to the consumer after the one just served, so it wraps at NUM_CONSUMERS.
    assign grant_next = (grant_inc == (IDX_BITS+1)'(NUM_CONSUMERS)) ? '0 : grant_inc[IDX_BITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr <= '0;
        else       rr_ptr <= rr_ptr_n;
    end
`endif

    // Find the first requester at or after scan_start, wrapping modulo NUM_CONSUMERS.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            cand = {1'b0, scan_start} + (IDX_BITS+1)'(i);
            if (cand >= (IDX_BITS+1)'(NUM_CONSUMERS))
                cand = cand - (IDX_BITS+1)'(NUM_CONSUMERS);
            if (!found && (consumer_read_valid[cand[IDX_BITS-1:0]] ||
                           consumer_write_valid[cand[IDX_BITS-1:0]])) begin
                found = 1'b1;
                pick  = cand[IDX_BITS-1:0];
            end
        end
    end

    // The ready bit is released only when the valid of the serviced operation drops.
    // The other valid of that consumer does not affect the release.
    assign relay_done = is_read ? !consumer_read_valid[grant] : !consumer_write_valid[grant];

    always_comb begin
        state_n                = state;
        grant_n                = grant;
        is_read_n              = is_read;
        consumer_read_ready_n  = consumer_read_ready;
        consumer_read_data_n   = consumer_read_data;
        consumer_write_ready_n = consumer_write_ready;
        mem_read_valid_n       = mem_read_valid;
        mem_read_address_n     = mem_read_address;
        mem_write_valid_n      = mem_write_valid;
        mem_write_address_n    = mem_write_address;
        mem_write_data_n       = mem_write_data;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        rr_ptr_n               = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    grant_n = pick;
                    // If the consumer requests both a read and a write, the read is serviced first.
                    if (consumer_read_valid[pick]) begin
                        is_read_n          = 1'b1;
                        mem_read_valid_n   = 1'b1;
                        mem_read_address_n = consumer_read_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                        state_n            = READ_WAIT;
                    end else begin
                        is_read_n           = 1'b0;
                        mem_write_valid_n   = 1'b1;
                        mem_write_address_n = consumer_write_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                        mem_write_data_n    = consumer_write_data[int'(pick)*DATA_BITS +: DATA_BITS];
                        state_n             = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_read_valid_n             = 1'b0;
                    consumer_read_ready_n[grant] = 1'b1;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (IDX_BITS'(i) == grant)
                            consumer_read_data_n[i*DATA_BITS +: DATA_BITS] = mem_read_data;
                    end
                    state_n = RELAY;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_n             = 1'b0;
                    consumer_write_ready_n[grant] = 1'b1;
                    state_n                       = RELAY;
                end
            end
            RELAY: begin
                if (relay_done) begin
                    consumer_read_ready_n  = '0;
                    consumer_write_ready_n = '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
                    rr_ptr_n               = grant_next;
`endif
                    state_n                = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            grant                <= '0;
            is_read              <= 1'b0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            state                <= state_n;
            grant                <= grant_n;
            is_read              <= is_read_n;
            consumer_read_ready  <= consumer_read_ready_n;
            consumer_read_data   <= consumer_read_data_n;
            consumer_write_ready <= consumer_write_ready_n;
            mem_read_valid       <= mem_read_valid_n;
            mem_read_address     <= mem_read_address_n;
            mem_write_valid      <= mem_write_valid_n;
            mem_write_address    <= mem_write_address_n;
            mem_write_data       <= mem_write_data_n;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter

module tb_data_mem_arbiter;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  consumer_read_valid;
    logic [N*8-1:0] consumer_read_address;
    logic [N-1:0]  consumer_read_ready;
    logic [N*8-1:0] consumer_read_data;
    logic [N-1:0]  consumer_write_valid;
    logic [N*8-1:0] consumer_write_address;
    logic [N*8-1:0] consumer_write_data;
    logic [N-1:0]  consumer_write_ready;
    logic          mem_read_valid;
    logic [7:0]    mem_read_address;
    logic          mem_read_ready;
    logic [7:0]    mem_read_data;
    logic          mem_write_valid;
    logic [7:0]    mem_write_address;
    logic [7:0]    mem_write_data;
    logic          mem_write_ready;

    data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
        .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
        .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
        .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
    );

    always #5 clk = ~clk;

    logic [105:0] all_outs;
    assign all_outs = {consumer_read_ready, consumer_read_data, consumer_write_ready, mem_read_valid,
                       mem_read_address, mem_write_valid, mem_write_address, mem_write_data};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: answers after mem_lat cycles, randomly when mem_rand, never when mem_stall.
    logic [7:0] mem_model [256];
    logic [7:0] ref_mem   [256];
    int cnt = 0;
    int mem_lat = 0;
    bit mem_stall = 0;
    bit mem_rand = 0;

    always @(negedge clk) begin
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        if (reset || mem_stall || !(mem_read_valid || mem_write_valid)) begin
            cnt = 0;
        end else if (mem_rand ? ($urandom_range(0, 1) == 1) : (cnt >= mem_lat)) begin
            cnt = 0;
            if (mem_read_valid) begin
                mem_read_ready = 1'b1;
                mem_read_data  = mem_model[mem_read_address];
            end else begin
                mem_write_ready = 1'b1;
                mem_model[mem_write_address] = mem_write_data;
            end
        end else begin
            cnt++;
        end
    end

    task automatic init_mem();
        for (int a = 0; a < 256; a++) begin
            mem_model[a] = 8'(a) ^ 8'h3C;
            ref_mem[a]   = 8'(a) ^ 8'h3C;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        consumer_read_valid = '0; consumer_write_valid = '0;
        consumer_read_address = '0; consumer_write_address = '0; consumer_write_data = '0;
        mem_stall = 0; mem_rand = 0; mem_lat = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int         cons;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         lat;
        logic [7:0] exp_rdata;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int n;
        bit seen_rd;
        mem_lat = v.lat;
        @(negedge clk);
        if (v.wr) begin
            consumer_write_address[v.cons*8 +: 8] = v.addr;
            consumer_write_data[v.cons*8 +: 8]    = v.wdata;
            consumer_write_valid[v.cons]          = 1'b1;
        end else begin
            consumer_read_address[v.cons*8 +: 8] = v.addr;
            consumer_read_valid[v.cons]          = 1'b1;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!(mem_read_valid || mem_write_valid) && n < 20);
        check("vec grant latency", n, 1);
        check("vec mem_read_valid", mem_read_valid, !v.wr);
        check("vec mem_write_valid", mem_write_valid, v.wr);
        check("vec mem address", v.wr ? mem_write_address : mem_read_address, v.addr);
        if (v.wr) check("vec mem_write_data", mem_write_data, v.wdata);
        n = 0;
        seen_rd = mem_read_valid;
        do begin
            @(negedge clk); n++;
            seen_rd |= mem_read_valid;
        end while ((consumer_read_ready | consumer_write_ready) == 0 && n < 20);
        check("vec ready latency", n, v.lat + 1);
        check("vec read ready vector", consumer_read_ready, v.wr ? 0 : (1 << v.cons));
        check("vec write ready vector", consumer_write_ready, v.wr ? (1 << v.cons) : 0);
        if (v.wr) check("vec no read activity", seen_rd, 0);
        else      check("vec read data slot", consumer_read_data[v.cons*8 +: 8], v.exp_rdata);
        consumer_read_valid[v.cons]  = 1'b0;
        consumer_write_valid[v.cons] = 1'b0;
        @(negedge clk);
        check("vec ready cleared", consumer_read_ready | consumer_write_ready, 0);
    endtask

    vec_t vecs [6];
    int   exp_order [4];
    int   got [4];
    int   ng, n, nops, g, expg, c;
    bit   both, done, prev, cur, opwr [2];
    logic [7:0] redo, wseen;
    int   st [N], hold [N], gap [N], waitc [N], maxw [N];
    bit   iswr [N];
    logic [7:0] ca [N], cd [N];
    int   ptr_m, last_g;
    bit   prev_v;

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{cons: 3, wr: 0, addr: 8'h10, wdata: 8'h00, lat: 2, exp_rdata: 8'hA5};
        vecs[1] = '{cons: 0, wr: 1, addr: 8'h20, wdata: 8'h7E, lat: 0, exp_rdata: 8'h00};
        vecs[2] = '{cons: 5, wr: 0, addr: 8'h20, wdata: 8'h00, lat: 1, exp_rdata: 8'h7E};
        vecs[3] = '{cons: 7, wr: 0, addr: 8'hFF, wdata: 8'h00, lat: 0, exp_rdata: 8'hC3};
        vecs[4] = '{cons: 1, wr: 1, addr: 8'hFF, wdata: 8'h00, lat: 3, exp_rdata: 8'h00};
        vecs[5] = '{cons: 2, wr: 0, addr: 8'hFF, wdata: 8'h00, lat: 2, exp_rdata: 8'h00};
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 2, 5, 0};
`endif
        init_mem();
        mem_model[8'h10] = 8'hA5;
        mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 0;

        // Reset state
        reset = 1'b1;
        consumer_read_valid = '0; consumer_write_valid = '0;
        consumer_read_address = '0; consumer_write_address = '0; consumer_write_data = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", all_outs, 0);
        reset = 1'b0;

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        check("slot 3 retained", consumer_read_data[3*8 +: 8], 8'hA5);

        // Same consumer reads and writes simultaneously
        do_reset();
        @(negedge clk);
        consumer_read_address[1*8 +: 8] = 8'h31;
        consumer_write_address[1*8 +: 8] = 8'h41;
        consumer_write_data[1*8 +: 8] = 8'h99;
        consumer_read_valid[1] = 1'b1;
        consumer_write_valid[1] = 1'b1;
        both = 0; done = 0; prev = 0; nops = 0; wseen = 0; opwr[0] = 1; opwr[1] = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (mem_read_valid && mem_write_valid) both = 1;
            cur = mem_read_valid || mem_write_valid;
            if (cur && !prev) begin
                if (nops < 2) opwr[nops] = mem_write_valid;
                if (mem_write_valid) wseen = mem_write_data;
                nops++;
            end
            prev = cur;
            if (consumer_read_ready[1]) consumer_read_valid[1] = 1'b0;
            if (consumer_write_ready[1]) begin consumer_write_valid[1] = 1'b0; done = 1; end
        end
        check("rw completed", done, 1);
        check("rw op count", nops, 2);
        check("rw read first", opwr[0], 0);
        check("rw write second", opwr[1], 1);
        check("rw never both valid", both, 0);
        check("rw write data", wseen, 8'h99);
        check("rw read data", consumer_read_data[1*8 +: 8], 8'h0D);

        // Contention among consumers 0, 2, 5
        do_reset();
        @(negedge clk);
        consumer_read_address[0*8 +: 8] = 8'h50;
        consumer_read_address[2*8 +: 8] = 8'h52;
        consumer_read_address[5*8 +: 8] = 8'h55;
        consumer_read_valid = 8'b0010_0101;
        ng = 0; redo = 0;
        got = '{-1, -1, -1, -1};
        for (int k = 0; k < 100 && ng < 4; k++) begin
            @(negedge clk);
            consumer_read_valid = consumer_read_valid | redo;
            redo = 0;
            for (int i = 0; i < N; i++) begin
                if (consumer_read_ready[i] && ng < 4) begin
                    got[ng] = i; ng++;
                    consumer_read_valid[i] = 1'b0;
                    redo[i] = 1'b1;
                end
            end
        end
        check("contention grant count", ng, 4);
        for (int k = 0; k < 4; k++) check($sformatf("contention grant %0d", k), got[k], exp_order[k]);

        // Held valid blocks other grants
        do_reset();
        @(negedge clk);
        consumer_read_address[6*8 +: 8] = 8'h66;
        consumer_read_valid[6] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!consumer_read_ready[6] && n < 20);
        check("held ready arrives", consumer_read_ready[6], 1);
        check("held read data", consumer_read_data[6*8 +: 8], 8'h5A);
        consumer_read_address[1*8 +: 8] = 8'h11;
        consumer_read_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("held ready stays, no grant", {consumer_read_ready, mem_read_valid, mem_write_valid},
                  {8'h40, 1'b0, 1'b0});
        end
        consumer_read_valid[6] = 1'b0;
        @(negedge clk);
        check("held ready drops", consumer_read_ready, 0);
        @(negedge clk);
        check("held next grant consumer 1", {mem_read_valid, mem_read_address}, {1'b1, 8'h11});

        // Reset during READ_WAIT
        do_reset();
        run_vec('{cons: 4, wr: 0, addr: 8'h44, wdata: 8'h00, lat: 0, exp_rdata: 8'h78});
        mem_stall = 1;
        @(negedge clk);
        consumer_read_address[6*8 +: 8] = 8'h66;
        consumer_read_valid[6] = 1'b1;
        @(negedge clk);
        check("stalled read pending", {mem_read_valid, mem_read_address}, {1'b1, 8'h66});
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async reset clears outputs", all_outs, 0);
        consumer_read_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        mem_stall = 0;
        consumer_read_address[4*8 +: 8] = 8'h44;
        consumer_read_address[6*8 +: 8] = 8'h66;
        consumer_read_valid = 8'b0101_0000;
        @(negedge clk);
        check("post-reset grant consumer 4", {mem_read_valid, mem_read_address}, {1'b1, 8'h44});

        // Randomized traffic against the reference model
        do_reset();
        init_mem();
        mem_rand = 1;
        ptr_m = 0; last_g = -1; prev_v = 0;
        for (int i = 0; i < N; i++) begin
            st[i] = 0; hold[i] = 0; gap[i] = $urandom_range(0, 3); waitc[i] = 0; maxw[i] = 0;
            iswr[i] = 0; ca[i] = 0; cd[i] = 0;
        end
        repeat (3000) begin
            @(negedge clk);
            check("rand exclusive mem valid", mem_read_valid & mem_write_valid, 0);
            check("rand ready one-hot", $countones(consumer_read_ready | consumer_write_ready) <= 1, 1);
            if ((mem_read_valid || mem_write_valid) && !prev_v) begin
                g = mem_read_valid ? int'(mem_read_address[2:0]) : int'(mem_write_address[2:0]);
                expg = -1;
                for (int k = 0; k < N; k++) begin
                    c = (ptr_m + k) % N;
                    if (expg < 0 && (consumer_read_valid[c] || consumer_write_valid[c])) expg = c;
                end
                check("rand grant", g, expg);
                check("rand op kind", mem_write_valid, iswr[g]);
                check("rand mem address", mem_read_valid ? mem_read_address : mem_write_address, ca[g]);
                if (mem_write_valid) check("rand mem data", mem_write_data, cd[g]);
                last_g = g;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
                ptr_m = (g + 1) % N;
`endif
            end
            prev_v = mem_read_valid || mem_write_valid;
            for (int i = 0; i < N; i++) begin
                if (consumer_read_ready[i] || consumer_write_ready[i]) begin
                    check("rand ready owner", i == last_g && st[i] != 0 && consumer_write_ready[i] == iswr[i], 1);
                    if (st[i] == 1) begin
                        if (!iswr[i]) check("rand read data", consumer_read_data[i*8 +: 8], ref_mem[ca[i]]);
                        else ref_mem[ca[i]] = cd[i];
                        st[i] = 2;
                        hold[i] = $urandom_range(0, 2);
                    end
                end
                if (st[i] == 1) waitc[i]++; else waitc[i] = 0;
                if (waitc[i] > maxw[i]) maxw[i] = waitc[i];
            end
            for (int i = 0; i < N; i++) begin
                if (st[i] == 0) begin
                    consumer_read_address[i*8 +: 8] = 8'($urandom);
                    consumer_write_address[i*8 +: 8] = 8'($urandom);
                    if (gap[i] > 0) gap[i]--;
                    else if ($urandom_range(0, 1) == 1) begin
                        iswr[i] = 1'($urandom_range(0, 1));
                        ca[i] = {5'($urandom_range(0, 31)), 3'(i)};
                        cd[i] = 8'($urandom);
                        if (iswr[i]) begin
                            consumer_write_address[i*8 +: 8] = ca[i];
                            consumer_write_data[i*8 +: 8] = cd[i];
                            consumer_write_valid[i] = 1'b1;
                        end else begin
                            consumer_read_address[i*8 +: 8] = ca[i];
                            consumer_read_valid[i] = 1'b1;
                        end
                        st[i] = 1;
                    end
                end else if (st[i] == 2) begin
                    if (hold[i] > 0) hold[i]--;
                    else begin
                        consumer_read_valid[i] = 1'b0;
                        consumer_write_valid[i] = 1'b0;
                        st[i] = 0;
                        gap[i] = $urandom_range(1, 3);
                    end
                end
            end
        end
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++) check($sformatf("rand wait bound %0d", i), maxw[i] <= 400, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
